game_round_sequencer: RTL
=========================

Name: game_round_sequencer

Overview:
- Top-level round sequencer for the VGA game.
- Takes the single-per-frame collision pulses from the collision controllers (obstacle hit, bonus hit) and the start key. Owns lives, score and the game state.
- Drives freeze, flash and game-over controls to the object movers and drawers.
- Sits between the collision controllers and the object/score display blocks. Everything is frame-paced by startOfFrame.

Parameters:
- START_LIVES, 3, lives loaded on round start (1..7)
- SCORE_W, 10, score width in bits; score saturates at 2^SCORE_W-1
- BONUS_PTS, 5, points added per bonus hit
- HIT_FRAMES, 60, frames spent in HIT state (freeze and flash) after an obstacle hit
- FLASH_DIV, 4, frames per flash half-period during HIT

Ports:
- clk  in  1  system clock
- resetN  in  1  asynchronous active-low reset
- startOfFrame  in  1  one-cycle pulse at start of each frame
- start_key  in  1  level from keypad, active high, synchronous to clk
- obstacle_hit  in  1  single-cycle pulse, at most one per frame
- bonus_hit  in  1  single-cycle pulse, at most one per frame
- game_state  out  2  00 IDLE, 01 PLAY, 10 HIT, 11 OVER
- lives  out  3  remaining lives
- score  out  SCORE_W  current score
- freeze  out  1  object movers hold position
- flash_on  out  1  player drawer blanks sprite when 1
- game_over  out  1  high in OVER

Behaviour:
- Reset values (async, resetN low):
  - state IDLE, lives=START_LIVES, score=0
  - freeze=1, flash_on=0, game_over=0
  - frame counter=0, start_key history register=0
- All outputs are registered. Each output reflects a state change one clk after the causing input cycle.
- start_key is edge-detected internally. Only a 0->1 transition counts as a press; holding the key does not repeat.
- IDLE:
  - freeze=1.
  - On press: go to PLAY, load lives=START_LIVES, clear score=0, clear frame counter.
- PLAY:
  - freeze=0, flash_on=0.
  - bonus_hit: score += BONUS_PTS, saturating at max. No wrap.
  - obstacle_hit with lives>1: lives -= 1, go to HIT, clear frame counter.
  - obstacle_hit with lives==1: lives=0, go to OVER.
  - Presses are ignored.
- Simultaneous obstacle_hit and bonus_hit in the same cycle: both are applied. Score is added and the life is lost; the state transition follows obstacle_hit.
- HIT:
  - freeze=1. obstacle_hit and bonus_hit are ignored (invulnerable).
  - Frame counter increments on each startOfFrame.
  - flash_on toggles on every startOfFrame at which (counter+1) mod FLASH_DIV == 0.
  - When the counter reaches HIT_FRAMES-1 and startOfFrame arrives: go to PLAY, flash_on=0, counter=0.
- OVER:
  - freeze=1, game_over=1.
  - Hits are ignored. score and lives are held for display.
  - On press: go to IDLE. lives and score keep their values until the next IDLE->PLAY load.
- The frame counter width must cover HIT_FRAMES-1 and must not overflow. In states other than HIT it is held at 0.
- Reset asserted mid-round (any state): immediate return to reset values. No pending hit survives.
- A press coinciding with a hit in PLAY: the press is ignored and the hit is processed.

Decomposition:
- Package game_seq_pkg holds:
  - enum game_state_t {IDLE=2'b00, PLAY=2'b01, HIT=2'b10, OVER=2'b11}
  - default constants for START_LIVES, HIT_FRAMES, FLASH_DIV
- One natural sub-module: frame_timer.
  - Counts startOfFrame pulses with clear and enable.
  - Outputs a done pulse at a programmable count and a flash toggle strobe.
  - It is reusable by other frame-paced blocks.
- The state FSM, lives and score stay in game_round_sequencer.

Test Plan:
1. Reset, then a start_key press (one high cycle) -> next clk: game_state=01, lives=3, score=0, freeze=0.
2. In PLAY, 4 bonus_hit pulses in separate frames -> score=20. With SCORE_W=5 and score=30, one bonus_hit -> score=31 (saturated).
3. In PLAY with lives=3, obstacle_hit -> lives=2, state=HIT, freeze=1. flash_on toggles after frames 4, 8, 12… Exactly 60 startOfFrame pulses later -> state=PLAY, flash_on=0. An obstacle_hit injected during HIT leaves lives=2.
4. Lives=1 with obstacle_hit and bonus_hit in the same cycle -> lives=0, score+5, state=OVER, game_over=1. Holding start_key high for 10 cycles gives one transition to IDLE. A second press -> PLAY with lives=3, score=0.
5. resetN pulsed low while in HIT at frame 30 -> outputs return to reset values asynchronously. After release, state=IDLE and the counter restarts at 0.

Source files
------------

// File: rtl/game_seq_pkg.sv
// rtl/game_seq_pkg.sv - shared state encoding and defaults for the round sequencer
`timescale 1ns/1ps
package game_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PLAY = 2'b01,
    HIT  = 2'b10,
    OVER = 2'b11
  } game_state_t;

  localparam int START_LIVES_DEF = 3;
  localparam int SCORE_W_DEF     = 10;
  localparam int BONUS_PTS_DEF   = 5;
  localparam int HIT_FRAMES_DEF  = 60;
  localparam int FLASH_DIV_DEF   = 4;

  // Bits needed to hold a frame count of 0..frames-1
  function automatic int timer_width(input int frames);
    return (frames < 2) ? 1 : $clog2(frames);
  endfunction

endpackage

// File: rtl/frame_timer.sv
// rtl/frame_timer.sv - startOfFrame counter with done pulse and flash toggle strobe
`timescale 1ns/1ps
module frame_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             tick,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] done_count,
  input  logic [CNT_W-1:0] flash_div,
  output logic             done,
  output logic             flash_strobe
);

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] flash_cnt;
  logic             step;

  // flash_cnt runs alongside count and tracks count mod flash_div without a divider
  assign step         = enable & tick;
  assign done         = step && (count == done_count);
  assign flash_strobe = step && (flash_cnt == (flash_div - CNT_W'(1)));

  // Frame counters: clear wins, wrap to 0 on done so the count never overflows
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count     <= '0;
      flash_cnt <= '0;
    end else if (clear) begin
      count     <= '0;
      flash_cnt <= '0;
    end else if (step) begin
      count     <= done ? '0 : count + CNT_W'(1);
      flash_cnt <= flash_strobe ? '0 : flash_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/game_round_sequencer.sv
// rtl/game_round_sequencer.sv - round FSM owning lives, score, freeze/flash/game-over
`timescale 1ns/1ps
module game_round_sequencer
  import game_seq_pkg::*;
#(
  parameter int START_LIVES = START_LIVES_DEF,
  parameter int SCORE_W     = SCORE_W_DEF,
  parameter int BONUS_PTS   = BONUS_PTS_DEF,
  parameter int HIT_FRAMES  = HIT_FRAMES_DEF,
  parameter int FLASH_DIV   = FLASH_DIV_DEF
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               start_key,
  input  logic               obstacle_hit,
  input  logic               bonus_hit,
  output logic [1:0]         game_state,
  output logic [2:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic               freeze,
  output logic               flash_on,
  output logic               game_over
);

  localparam int CNT_W = timer_width(HIT_FRAMES);

  game_state_t        state, state_n;
  logic [2:0]         lives_n;
  logic [SCORE_W-1:0] score_n;
  logic               flash_n;
  logic               key_q;
  logic               press;
  logic               hit_done;
  logic               flash_strobe;
  logic [SCORE_W:0]   score_sum;

  assign press      = start_key & ~key_q;
  assign game_state = state;
  assign score_sum  = {1'b0, score} + (SCORE_W + 1)'(BONUS_PTS);

  // Counter only runs in HIT; everywhere else it is held cleared
  frame_timer #(.CNT_W(CNT_W)) u_frame_timer (
    .clk          (clk),
    .resetN       (resetN),
    .tick         (startOfFrame),
    .clear        (state != HIT),
    .enable       (state == HIT),
    .done_count   (CNT_W'(HIT_FRAMES - 1)),
    .flash_div    (CNT_W'(FLASH_DIV)),
    .done         (hit_done),
    .flash_strobe (flash_strobe)
  );

  // Next-state, lives, score and flash decisions
  always_comb begin
    state_n = state;
    lives_n = lives;
    score_n = score;
    flash_n = flash_on;
    case (state)
      IDLE: begin
        if (press) begin
          state_n = PLAY;
          lives_n = 3'(START_LIVES);
          score_n = '0;
        end
      end
      PLAY: begin
        flash_n = 1'b0;
        if (bonus_hit)
          score_n = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
        if (obstacle_hit) begin
          if (lives > 3'd1) begin
            lives_n = lives - 3'd1;
            state_n = HIT;
          end else begin
            lives_n = 3'd0;
            state_n = OVER;
          end
        end
      end
      HIT: begin
        if (hit_done) begin
          state_n = PLAY;
          flash_n = 1'b0;
        end else if (flash_strobe) begin
          flash_n = ~flash_on;
        end
      end
      OVER: begin
        if (press) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Register state and all outputs; freeze/game_over follow the next state
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      lives     <= 3'(START_LIVES);
      score     <= '0;
      freeze    <= 1'b1;
      flash_on  <= 1'b0;
      game_over <= 1'b0;
      key_q     <= 1'b0;
    end else begin
      state     <= state_n;
      lives     <= lives_n;
      score     <= score_n;
      freeze    <= (state_n != PLAY);
      flash_on  <= flash_n;
      game_over <= (state_n == OVER);
      key_q     <= start_key;
    end
  end

endmodule
